// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the register-file write port.
// Valid/ready: a transfer on port i happens at a posedge where reqi_valid && reqi_ready; valid never waits on ready.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // master: the requesters plus whoever observes the register-file write port
    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, wr_addr, wr_data
    );

    // slave: the arbiter itself
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between pipeline writeback (port 0)
// and the mul/div unit (port 1); registers the winner and drops writes to register 0.
module regfile_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    regfile_wb_arbiter_if.slave bus,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic             dbg_prio
);

    logic              prio;
    logic              both_valid;
    logic              ready0;
    logic              ready1;
    logic              xfer0;
    logic              xfer1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_write;

    assign both_valid = bus.req0_valid && bus.req1_valid;

    // Ready depends only on valid, hold, prio and rst, so at most one port is granted per cycle.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (!rst && !hold) begin
            if (both_valid) begin
                ready0 = !prio;
                ready1 = prio;
            end else begin
                ready0 = bus.req0_valid;
                ready1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    assign xfer0     = bus.req0_valid && ready0;
    assign xfer1     = bus.req1_valid && ready1;
    assign xfer      = xfer0 || xfer1;
    assign sel_addr  = xfer1 ? bus.req1_addr : bus.req0_addr;
    assign sel_data  = xfer1 ? bus.req1_data : bus.req0_data;
    // Register 0 is hardwired; its handshake still completes but nothing is written.
    assign sel_write = xfer && (sel_addr != '0);

    // The winner's port loses priority next time, giving strict alternation under contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (xfer) begin
            prio <= xfer0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= sel_write;
            if (sel_write) begin
                bus.wr_addr <= sel_addr;
                bus.wr_data <= sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (both_valid && !hold && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign dbg_prio = prio;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus pushes expected writes, a negedge monitor pops them.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic rst2 = 1'b1;
    logic hold2 = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus2 ();

    logic [CNT_W-1:0] conflict_cnt;
    logic             dbg_prio;
    logic [1:0]       conflict_cnt2;
    logic             dbg_prio2;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .bus          (bus.slave),
        .conflict_cnt (conflict_cnt),
        .dbg_prio     (dbg_prio)
    );

    // Narrow counter instance used only for the saturation check.
    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst          (rst2),
        .hold         (hold2),
        .bus          (bus2.slave),
        .conflict_cnt (conflict_cnt2),
        .dbg_prio     (dbg_prio2)
    );

    // ---------------- scoreboard ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the write port presents wr_en, it must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none",
                         bus.wr_addr, bus.wr_data);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== e) begin
                    bad++;
                    $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             bus.wr_addr, bus.wr_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a posedge: applies one cycle of inputs, checks the expected grants,
    // queues the expected write, then advances past the next posedge.
    task automatic stim(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                        input logic h, input logic r, input logic e0, input logic e1,
                        input string name);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        hold = h;
        rst  = r;
        #1;
        chk({name, "_ready0"}, {63'd0, bus.req0_ready}, {63'd0, e0});
        chk({name, "_ready1"}, {63'd0, bus.req1_ready}, {63'd0, e1});
        if (e0 && a0 != '0) exp_q.push_back({a0, d0});
        if (e1 && a1 != '0) exp_q.push_back({a1, d1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name);
        stim(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.req0_valid = 1'b1;
        bus2.req0_addr  = 5'd1;
        bus2.req0_data  = 64'h1;
        bus2.req1_valid = 1'b1;
        bus2.req1_addr  = 5'd2;
        bus2.req1_data  = 64'h2;
        bus.req0_valid  = 1'b0;
        bus.req0_addr   = '0;
        bus.req0_data   = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_addr   = '0;
        bus.req1_data   = '0;
        #1;

        // Reset with both requesters valid: no grants, then everything cleared.
        stim(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 1'b1, 1'b0, 1'b0, "rst_c0");
        stim(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 1'b1, 1'b0, 1'b0, "rst_c1");
        chk("rst_wr_en",   {63'd0, bus.wr_en}, 64'd0);
        chk("rst_wr_addr", {59'd0, bus.wr_addr}, 64'd0);
        chk("rst_wr_data", bus.wr_data, 64'd0);
        chk("rst_cnt",     {56'd0, conflict_cnt}, 64'd0);
        chk("rst_prio",    {63'd0, dbg_prio}, 64'd0);

        // Single requester 0, then single requester 1 to bring prio back to 0.
        stim(1'b1, 5'd3, 64'hAA, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "single0");
        chk("single0_wr_en", {63'd0, bus.wr_en}, 64'd1);
        chk("single0_prio",  {63'd0, dbg_prio}, 64'd1);
        idle("single0_gap");
        chk("single0_wr_en_off", {63'd0, bus.wr_en}, 64'd0);
        stim(1'b0, '0, '0, 1'b1, 5'd4, 64'hBB, 1'b0, 1'b0, 1'b0, 1'b1, "single1");
        chk("single1_prio", {63'd0, dbg_prio}, 64'd0);
        idle("single1_gap");

        // Contention: requesters hold data until accepted; grants alternate 0,1,0,1.
        stim(1'b1, 5'd1, 64'h100, 1'b1, 5'd2, 64'h200, 1'b0, 1'b0, 1'b1, 1'b0, "cont0");
        stim(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h200, 1'b0, 1'b0, 1'b0, 1'b1, "cont1");
        stim(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h201, 1'b0, 1'b0, 1'b1, 1'b0, "cont2");
        stim(1'b1, 5'd1, 64'h102, 1'b1, 5'd2, 64'h201, 1'b0, 1'b0, 1'b0, 1'b1, "cont3");
        chk("cont_cnt", {56'd0, conflict_cnt}, 64'd4);
        idle("cont_drain");

        // Register zero: handshake completes and prio flips, but no write.
        stim(1'b1, 5'd5, 64'h77, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "zero_pre");
        chk("zero_pre_prio", {63'd0, dbg_prio}, 64'd1);
        stim(1'b0, '0, '0, 1'b1, 5'd0, 64'h55, 1'b0, 1'b0, 1'b0, 1'b1, "zero");
        chk("zero_prio",    {63'd0, dbg_prio}, 64'd0);
        chk("zero_wr_en",   {63'd0, bus.wr_en}, 64'd0);
        chk("zero_wr_data", bus.wr_data, 64'h77);
        chk("zero_wr_addr", {59'd0, bus.wr_addr}, 64'd5);

        // Hold with both valid: no grants, counter frozen.
        for (int i = 0; i < 3; i++)
            stim(1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h67, 1'b1, 1'b0, 1'b0, 1'b0, "hold");
        chk("hold_wr_en", {63'd0, bus.wr_en}, 64'd0);
        chk("hold_cnt",   {56'd0, conflict_cnt}, 64'd4);
        stim(1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h67, 1'b0, 1'b0, 1'b1, 1'b0, "release");
        chk("release_cnt", {56'd0, conflict_cnt}, 64'd5);
        // Reset in the cycle after the accept: the registered write shows this cycle, then clears.
        stim(1'b0, '0, '0, 1'b1, 5'd7, 64'h67, 1'b0, 1'b1, 1'b0, 1'b0, "midrst");
        chk("midrst_wr_en",   {63'd0, bus.wr_en}, 64'd0);
        chk("midrst_wr_data", bus.wr_data, 64'd0);
        chk("midrst_cnt",     {56'd0, conflict_cnt}, 64'd0);
        chk("midrst_prio",    {63'd0, dbg_prio}, 64'd0);
        stim(1'b0, '0, '0, 1'b1, 5'd7, 64'h67, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");

        // Same-address contention: last accepted write wins.
        stim(1'b1, 5'd9, 64'h90, 1'b1, 5'd9, 64'h91, 1'b0, 1'b0, 1'b1, 1'b0, "same0");
        stim(1'b0, '0, '0, 1'b1, 5'd9, 64'h91, 1'b0, 1'b0, 1'b0, 1'b1, "same1");
        idle("same_drain");
        chk("same_final_data", bus.wr_data, 64'h91);
        idle("end_gap");
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        // Saturation on the 2-bit counter instance.
        chk("sat_rst_cnt", {62'd0, conflict_cnt2}, 64'd0);
        rst2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk("sat_cnt", {62'd0, conflict_cnt2}, (k < 3) ? 64'(k) : 64'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the register file. Two writeback sources share the single write port: the in-order pipeline writeback and the multi-cycle mul/div unit. The block accepts at most one request per cycle using round-robin priority. It registers the winner onto the register-file write port and drops writes to register 0. It sits between the writeback stage and the register file, and honours a hold from the hazard unit.

## Interface
Parameters:
- DATA_W, 64, register data width
- ADDR_W, 5, register index width
- CNT_W, 8, width of the saturating conflict counter

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- hold  in  1  hazard-unit freeze; no grants while high
- req0_valid  in  1  pipeline writeback request
- req0_addr  in  ADDR_W  destination register
- req0_data  in  DATA_W  write data
- req0_ready  out  1  grant/accept for requester 0
- req1_valid  in  1  mul/div writeback request
- req1_addr  in  ADDR_W  destination register
- req1_data  in  DATA_W  write data
- req1_ready  out  1  grant/accept for requester 1
- wr_en  out  1  register-file write enable
- wr_addr  out  ADDR_W  register-file write index
- wr_data  out  DATA_W  register-file write data
- conflict_cnt  out  CNT_W  saturating count of contended cycles

## Operation
- Handshake: a transfer on port i occurs in a cycle where reqi_valid && reqi_ready at posedge. Requesters hold valid/addr/data stable until they are accepted. Valid must not depend on ready.
- readyi is combinational from valid, hold, prio and rst only:
  - rst=1 or hold=1: both ready=0.
  - Only one valid: that port's ready=1.
  - Both valid: ready=1 only for the port indexed by prio.
  - At most one ready is high in any cycle.
- prio is a 1-bit register, reset 0 (requester 0 favoured). On any transfer from port g, prio <= ~g, whether or not the other port was valid. With no transfer, prio holds.
- Output register, on every posedge:
  - If there is a transfer with addr != 0: wr_en<=1, wr_addr<=addr, wr_data<=data.
  - Otherwise: wr_en<=0; wr_addr and wr_data hold their previous values.
- Address 0: the handshake completes normally and prio updates, but wr_en stays 0.
- conflict_cnt increments when req0_valid && req1_valid && !hold. It saturates at all-ones and never wraps.
- No state other than prio, the output register and conflict_cnt. The block uses no FSM beyond the prio bit.

## Timing
- Accept-to-write latency is one cycle. A transfer at edge N produces wr_en=1 during cycle N+1, and the register file commits at edge N+1.
- Throughput is one write per cycle. Back-to-back transfers from the same or alternating ports are allowed.
- Under continuous contention, grants strictly alternate 0,1,0,1…, so the maximum wait for either port is one cycle.
- hold: grants stop in the same cycle hold is high. The output register still updates, so wr_en deasserts one edge after hold rises. An in-flight registered write from the prior edge still completes.
- Reset values (after a posedge with rst=1): wr_en=0, wr_addr=0, wr_data=0, prio=0, conflict_cnt=0. req*_ready=0 while rst is high.
- Reset mid-operation: a request pending during reset is not accepted. The registered write is cancelled (wr_en=0 from the next edge). No partial state survives.
- Simultaneous same-address requests: arbitrated normally. The loser's write follows one or more cycles later and overwrites, giving last-accepted-wins ordering.

## Test plan
- Reset: assert rst for 2 cycles with both valid=1. Expect ready0=ready1=0, then wr_en=0, wr_addr=0, wr_data=0 and conflict_cnt=0.
- Single requester: req0 (addr=3, data=0xAA) for one cycle. Expect ready0=1, then wr_en=1, wr_addr=3, wr_data=0xAA the next cycle, and wr_en=0 the cycle after.
- Contention: both valid for 4 cycles (addr 1/2, distinct data). Expect grants 0,1,0,1, writes to 1,2,1,2 each one cycle later, and conflict_cnt=4.
- Register zero: req1 addr=0, data=0x55. Expect ready1=1 and prio flips to 0, but wr_en stays 0 and wr_data is unchanged.
- Hold and reset mid-stream: both valid, hold=1 for 3 cycles. Expect no readies, wr_en=0 and conflict_cnt unchanged. Release hold and expect the grant to go to prio. Then assert rst in the cycle after an accept and expect wr_en=0 on the next edge.
- Saturation: CNT_W=2 with both valid for 6 cycles. Expect conflict_cnt to reach 3 and stay at 3.
